table_scan_seq: RTL and testbench

TABLE_SCAN_SEQ -- requirements
Module: table_scan_seq

---
 rtl/table_scan_pkg.sv | 20 ++
 rtl/table_scan_idx.sv | 72 +++++++
 rtl/table_scan_seq.sv | 167 ++++++++++++++++
 tb/tb_table_scan_seq.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/table_scan_pkg.sv
// Shared types and default dimensions for the table scan sequencer.
package table_scan_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DEF_PLANES = 2;
  localparam int unsigned DEF_ROWS   = 3;
  localparam int unsigned DEF_COLS   = 4;

  // Index width for a dimension of n entries, never narrower than one bit
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/table_scan_idx.sv
// Plane/row/column coordinate counter with wrap and last-beat detection.
module table_scan_idx
  import table_scan_pkg::*;
#(
  parameter int unsigned PLANES = DEF_PLANES,
  parameter int unsigned ROWS   = DEF_ROWS,
  parameter int unsigned COLS   = DEF_COLS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load_i,
  input  logic                       single_i,
  input  logic [idx_w(PLANES)-1:0]   plane_i,
  input  logic                       adv_i,
  output logic [idx_w(PLANES)-1:0]   plane_o,
  output logic [idx_w(ROWS)-1:0]     row_o,
  output logic [idx_w(COLS)-1:0]     col_o,
  output logic                       last_c_o
);

  localparam int unsigned PW = idx_w(PLANES);
  localparam int unsigned RW = idx_w(ROWS);
  localparam int unsigned CW = idx_w(COLS);

  logic [PW-1:0] r_plane;
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic          r_single;

  logic w_col_last;
  logic w_row_last;
  logic w_plane_last;

  assign w_col_last   = (r_col   == CW'(COLS - 1));
  assign w_row_last   = (r_row   == RW'(ROWS - 1));
  assign w_plane_last = (r_plane == PW'(PLANES - 1));

  // A single-plane scan ends at the last row of its plane
  assign last_c_o = w_col_last && w_row_last && (r_single || w_plane_last);

  assign plane_o = r_plane;
  assign row_o   = r_row;
  assign col_o   = r_col;

  // Load start coordinates, then step col fastest, then row, then plane
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_plane  <= '0;
      r_row    <= '0;
      r_col    <= '0;
      r_single <= 1'b0;
    end else if (load_i) begin
      r_plane  <= plane_i;
      r_row    <= '0;
      r_col    <= '0;
      r_single <= single_i;
    end else if (adv_i) begin
      if (!w_col_last) begin
        r_col <= r_col + CW'(1);
      end else begin
        r_col <= '0;
        if (!w_row_last) begin
          r_row <= r_row + RW'(1);
        end else begin
          r_row   <= '0;
          r_plane <= w_plane_last ? '0 : r_plane + PW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/table_scan_seq.sv
// Streams the bits of a constant 3-D table as valid/ready beats and counts ones.
// Optional feature: define TABLE_SCAN_PARITY_EN to add the parity_o output.
module table_scan_seq
  import table_scan_pkg::*;
#(
  parameter int unsigned PLANES = DEF_PLANES,
  parameter int unsigned ROWS   = DEF_ROWS,
  parameter int unsigned COLS   = DEF_COLS,
  parameter logic TABLE [PLANES-1:0][ROWS-1:0][COLS-1:0] = '{
    '{'{1'b0, 1'b1, 1'b0, 1'b1}, '{1'b0, 1'b1, 1'b1, 1'b1}, '{1'b0, 1'b1, 1'b1, 1'b1}},
    '{'{1'b0, 1'b1, 1'b1, 1'b1}, '{1'b0, 1'b1, 1'b1, 1'b1}, '{1'b0, 1'b1, 1'b1, 1'b1}}
  }
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start_i,
  input  logic                                  single_i,
  input  logic [idx_w(PLANES)-1:0]              plane_sel_i,
  input  logic                                  abort_i,
  output logic                                  out_valid_o,
  input  logic                                  out_ready_i,
  output logic                                  out_bit_o,
  output logic [idx_w(PLANES)-1:0]              out_plane_o,
  output logic [idx_w(ROWS)-1:0]                out_row_o,
  output logic [idx_w(COLS)-1:0]                out_col_o,
  output logic                                  busy_o,
  output logic                                  done_o,
  output logic [$clog2(PLANES*ROWS*COLS+1)-1:0] ones_o
`ifdef TABLE_SCAN_PARITY_EN
  ,
  output logic                                  parity_o
`endif
);

  localparam int unsigned PW = idx_w(PLANES);
  localparam int unsigned RW = idx_w(ROWS);
  localparam int unsigned CW = idx_w(COLS);
  localparam int unsigned OW = $clog2(PLANES * ROWS * COLS + 1);

  state_e        r_state;
  state_e        w_state_nxt;
  logic          w_load;
  logic          w_hs;
  logic          w_last;
  logic [PW-1:0] w_start_plane;
  logic [PW-1:0] w_plane;
  logic [RW-1:0] w_row;
  logic [CW-1:0] w_col;
  logic          r_valid;
  logic          r_busy;
  logic          r_done;
  logic [OW-1:0] r_ones;

  assign w_hs = r_valid & out_ready_i;

  // Out-of-range plane selects fall back to plane 0
  always_comb begin
    w_start_plane = '0;
    if (single_i && (32'(plane_sel_i) < PLANES)) begin
      w_start_plane = plane_sel_i;
    end
  end

  // Next-state logic; abort wins over a coincident last beat
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start_i) begin
          w_state_nxt = SCAN;
          w_load      = 1'b1;
        end
      end
      SCAN: begin
        if (abort_i) begin
          w_state_nxt = IDLE;
        end else if (w_hs && w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Status outputs registered from the next state so they align with r_state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_valid <= (w_state_nxt == SCAN);
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= (w_state_nxt == DONE);
    end
  end

  // Ones counter: cleared at start, bumps on each accepted 1-bit, holds otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ones <= '0;
    end else if (w_load) begin
      r_ones <= '0;
    end else if (w_hs && out_bit_o) begin
      r_ones <= r_ones + OW'(1);
    end
  end

`ifdef TABLE_SCAN_PARITY_EN
  logic r_parity;

  // Running XOR of accepted bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity <= 1'b0;
    end else if (w_load) begin
      r_parity <= 1'b0;
    end else if (w_hs) begin
      r_parity <= r_parity ^ out_bit_o;
    end
  end

  assign parity_o = r_parity;
`endif

  table_scan_idx #(
    .PLANES (PLANES),
    .ROWS   (ROWS),
    .COLS   (COLS)
  ) u_idx (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (w_load),
    .single_i (single_i),
    .plane_i  (w_start_plane),
    .adv_i    (w_hs),
    .plane_o  (w_plane),
    .row_o    (w_row),
    .col_o    (w_col),
    .last_c_o (w_last)
  );

  assign out_bit_o   = TABLE[w_plane][w_row][w_col];
  assign out_plane_o = w_plane;
  assign out_row_o   = w_row;
  assign out_col_o   = w_col;
  assign out_valid_o = r_valid;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign ones_o      = r_ones;

endmodule

// File: tb/tb_table_scan_seq.sv
// Scoreboard bench for table_scan_seq with the default table.
// Build with TABLE_SCAN_PARITY_EN defined to also check parity_o.
module tb_table_scan_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0;
  logic       single_i = 1'b0;
  logic [0:0] plane_sel_i = '0;
  logic       abort_i = 1'b0;
  logic       out_ready_i = 1'b0;
  logic       out_valid_o;
  logic       out_bit_o;
  logic [0:0] out_plane_o;
  logic [1:0] out_row_o;
  logic [1:0] out_col_o;
  logic       busy_o;
  logic       done_o;
  logic [4:0] ones_o;
`ifdef TABLE_SCAN_PARITY_EN
  logic       parity_o;
`endif

  int n_total = 0;
  int n_bad   = 0;

  typedef struct packed {
    logic       b;
    logic [0:0] p;
    logic [1:0] r;
    logic [1:0] c;
  } beat_t;

  beat_t q[$];

  always #5 clk = ~clk;

  table_scan_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .single_i    (single_i),
    .plane_sel_i (plane_sel_i),
    .abort_i     (abort_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_bit_o   (out_bit_o),
    .out_plane_o (out_plane_o),
    .out_row_o   (out_row_o),
    .out_col_o   (out_col_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .ones_o      (ones_o)
`ifdef TABLE_SCAN_PARITY_EN
    ,
    .parity_o    (parity_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference table: every row is 0111 (bit3..bit0) except plane 1 row 2 = 0101
  function automatic logic ref_bit(input int p, input int r, input int c);
    logic [3:0] row;
    row = (p == 1 && r == 2) ? 4'b0101 : 4'b0111;
    return row[c];
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, 32'(out_valid_o), 32'd0);
    chk({tag, "_busy"},  32'(busy_o),      32'd0);
    chk({tag, "_done"},  32'(done_o),      32'd0);
  endtask

  // Runs one scan; abort_at < 0 means no abort, otherwise abort is raised once
  // abort_at beats have been accepted, with out_ready_i = abort_rdy in that cycle.
  task automatic run_scan(input logic single, input logic [0:0] sel, input bit toggle,
                          input int abort_at, input bit abort_rdy,
                          input int exp_beats, input int exp_final, input string tag);
    int     p0, np, hs, exp_ones, phase;
    logic   par;
    logic [3:0] first4;
    bit     fin;
    beat_t  b;

    q.delete();
    p0 = single ? int'(sel) : 0;
    np = single ? 1 : 2;
    for (int p = p0; p < p0 + np; p++)
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 4; c++)
          q.push_back(beat_t'{b: ref_bit(p, r, c), p: 1'(p), r: 2'(r), c: 2'(c)});

    @(posedge clk); #1;
    start_i     = 1'b1;
    single_i    = single;
    plane_sel_i = sel;
    out_ready_i = 1'b1;
    abort_i     = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b0;

    phase = 1; hs = 0; exp_ones = 0; par = 1'b0; first4 = '0; fin = 1'b0;
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      out_ready_i = toggle ? ~cyc[0] : 1'b1;
      start_i     = (toggle && phase != 0) ? cyc[1] : 1'b0;
      abort_i     = 1'b0;
      if (abort_at >= 0 && phase == 1 && hs == abort_at) begin
        abort_i     = 1'b1;
        out_ready_i = abort_rdy;
      end
      @(negedge clk);
      case (phase)
        1: begin
          chk({tag, "_valid"}, 32'(out_valid_o), 32'd1);
          chk({tag, "_busy"},  32'(busy_o),      32'd1);
          chk({tag, "_done"},  32'(done_o),      32'd0);
          chk({tag, "_ones"},  32'(ones_o),      32'(exp_ones));
          if (q.size() == 0) begin
            chk({tag, "_overrun"}, 32'd0, 32'd1);
            fin = 1'b1;
          end else begin
            chk({tag, "_bit"},   32'(out_bit_o),   32'(q[0].b));
            chk({tag, "_plane"}, 32'(out_plane_o), 32'(q[0].p));
            chk({tag, "_row"},   32'(out_row_o),   32'(q[0].r));
            chk({tag, "_col"},   32'(out_col_o),   32'(q[0].c));
            if (single && sel == 1'b1 && out_row_o == 2'd2 && out_col_o == 2'd1)
              chk({tag, "_p1r2c1"}, 32'(out_bit_o), 32'd0);
            if (out_ready_i) begin
              b = q.pop_front();
              exp_ones = exp_ones + int'(b.b);
              par = par ^ b.b;
              if (hs < 4) first4[hs] = b.b;
              hs++;
            end
            if (abort_i) begin
              phase = 0;
              q.delete();
            end else if (q.size() == 0) begin
              phase = 2;
            end
          end
        end
        2: begin
          chk({tag, "_done_pulse"}, 32'(done_o),      32'd1);
          chk({tag, "_done_valid"}, 32'(out_valid_o), 32'd0);
          chk({tag, "_done_busy"},  32'(busy_o),      32'd1);
          chk({tag, "_done_ones"},  32'(ones_o),      32'(exp_ones));
`ifdef TABLE_SCAN_PARITY_EN
          chk({tag, "_parity"}, 32'(parity_o), 32'(par));
          if (!single) chk({tag, "_parity_full"}, 32'(parity_o), 32'd1);
`endif
          phase = 0;
        end
        default: begin
          chk_idle_outputs({tag, "_end"});
          chk({tag, "_end_ones"},  32'(ones_o), 32'(exp_ones));
          chk({tag, "_final_ones"}, 32'(ones_o), 32'(exp_final));
          chk({tag, "_beats"},     32'(hs),     32'(exp_beats));
          if (!single && abort_at < 0)
            chk({tag, "_first4"}, 32'(first4), 32'b0111);
          fin = 1'b1;
        end
      endcase
      if (!fin) begin
        @(posedge clk); #1;
      end
    end
    if (!fin) chk({tag, "_timeout"}, 32'd0, 32'd1);
    start_i = 1'b0;
    abort_i = 1'b0;
    // Count must hold and no late done pulse while idle
    repeat (3) begin
      @(negedge clk);
      chk({tag, "_hold_done"}, 32'(done_o), 32'd0);
      chk({tag, "_hold_ones"}, 32'(ones_o), 32'(exp_final));
    end
  endtask

  initial begin
    #12;
    chk_idle_outputs("rst");
    chk("rst_ones",  32'(ones_o),      32'd0);
    chk("rst_plane", 32'(out_plane_o), 32'd0);
    chk("rst_row",   32'(out_row_o),   32'd0);
    chk("rst_col",   32'(out_col_o),   32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;

    run_scan(1'b0, 1'b0, 1'b0, -1, 1'b0, 24, 17, "full");
    run_scan(1'b1, 1'b1, 1'b0, -1, 1'b0, 12, 8,  "single1");
    run_scan(1'b1, 1'b0, 1'b0, -1, 1'b0, 12, 9,  "single0");
    run_scan(1'b0, 1'b0, 1'b1, -1, 1'b0, 24, 17, "stall");
    // First five beats carry bits 1,1,1,0,1
    run_scan(1'b0, 1'b0, 1'b0, 5, 1'b0, 5, 4, "abort");
    // Abort together with the sixth handshake: that beat (bit 1) still counts
    run_scan(1'b0, 1'b0, 1'b0, 5, 1'b1, 6, 5, "abort_hs");

    // Reset in the middle of a scan
    @(posedge clk); #1;
    start_i = 1'b1; single_i = 1'b0; out_ready_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("pre_rst_busy", 32'(busy_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("mid_rst");
    chk("mid_rst_ones",  32'(ones_o),      32'd0);
    chk("mid_rst_plane", 32'(out_plane_o), 32'd0);
    chk("mid_rst_row",   32'(out_row_o),   32'd0);
    chk("mid_rst_col",   32'(out_col_o),   32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk_idle_outputs("post_rst");
    end
    run_scan(1'b0, 1'b0, 1'b0, -1, 1'b0, 24, 17, "after_rst");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
